// File: rtl/ub_writeback_deskew_if.sv
// Array-to-unified-buffer write-back bundle: skewed column partial sums in,
// deskewed row writes and tile status out.
interface ub_writeback_deskew_if #(
    parameter int SIZE              = 8,
    parameter int PARTIAL_SUM_WIDTH = 8 + 4 + 4 + $clog2(SIZE),
    parameter int ADDR_WIDTH        = 6
);
    logic                                Start;
    logic [SIZE-1:0]                     Psum_Valid;
    logic signed [PARTIAL_SUM_WIDTH-1:0] Psum_In [SIZE];
    logic                                Wr_en;
    logic [ADDR_WIDTH-1:0]               Wr_Addr;
    logic signed [PARTIAL_SUM_WIDTH-1:0] Wr_Data [SIZE];
    logic                                Busy;
    logic                                Done;
    logic                                Skew_Err;

    modport master (
        output Start, Psum_Valid, Psum_In,
        input  Wr_en, Wr_Addr, Wr_Data, Busy, Done, Skew_Err
    );

    modport slave (
        input  Start, Psum_Valid, Psum_In,
        output Wr_en, Wr_Addr, Wr_Data, Busy, Done, Skew_Err
    );
endinterface

// File: rtl/ub_writeback_deskew.sv
// Realigns the diagonally skewed column outputs of the systolic array into
// full rows and writes one row per cycle into the unified buffer.
module ub_writeback_deskew #(
    parameter int SIZE              = 8,
    parameter int PARTIAL_SUM_WIDTH = 8 + 4 + 4 + $clog2(SIZE),
    parameter int ADDR_WIDTH        = 6
) (
    input logic                  clk,
    input logic                  rst_n,
    ub_writeback_deskew_if.slave bus
);
    localparam int RW = $clog2(SIZE);
    localparam int W  = PARTIAL_SUM_WIDTH;

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            collect;
    logic            enter;
    logic            row_wr;
    logic            skew;
    logic            last_wr;
    logic [RW-1:0]   row_cnt;
    logic [SIZE-1:0] vin;
    logic [SIZE-1:0] al_valid;
    logic [W-1:0]    al_data [SIZE];

    assign collect = state == COLLECT;
    assign enter   = bus.Start && !collect;
    assign vin     = collect ? bus.Psum_Valid : '0;
    assign row_wr  = collect && (&al_valid);
    assign skew    = collect && (|al_valid) && !(&al_valid);

    // Column j waits SIZE-1-j cycles so that all columns of a row line up.
    for (genvar j = 0; j < SIZE; j++) begin : g_col
        localparam int D = SIZE - 1 - j;
        if (D == 0) begin : g_pass
            assign al_data[j]  = bus.Psum_In[j];
            assign al_valid[j] = vin[j];
        end else begin : g_dly
            logic [W-1:0] d_q [D];
            logic [D-1:0] v_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= '0;
                    for (int k = 0; k < D; k++) d_q[k] <= '0;
                end else begin
                    d_q[0] <= bus.Psum_In[j];
                    for (int k = 1; k < D; k++) d_q[k] <= d_q[k-1];
                    v_q <= enter ? '0 : ((v_q << 1) | D'(vin[j]));
                end
            end

            assign al_data[j]  = d_q[D-1];
            assign al_valid[j] = v_q[D-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bus.Busy  = 1'b0;
        bus.Done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.Start) state_nxt = COLLECT;
            end
            COLLECT: begin
                bus.Busy = 1'b1;
                if (last_wr) state_nxt = DONE;
            end
            DONE: begin
                bus.Done  = 1'b1;
                state_nxt = bus.Start ? COLLECT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.Wr_en    <= 1'b0;
            bus.Wr_Addr  <= '0;
            bus.Skew_Err <= 1'b0;
            row_cnt      <= '0;
            last_wr      <= 1'b0;
            for (int j = 0; j < SIZE; j++) bus.Wr_Data[j] <= '0;
        end else begin
            bus.Wr_en <= row_wr;
            last_wr   <= row_wr && (row_cnt == RW'(SIZE - 1));
            if (enter) begin
                row_cnt      <= '0;
                bus.Skew_Err <= 1'b0;
            end
            if (row_wr) begin
                bus.Wr_Addr <= {row_cnt, {RW{1'b0}}};
                row_cnt     <= row_cnt + 1'b1;
                for (int j = 0; j < SIZE; j++) bus.Wr_Data[j] <= al_data[j];
            end
            // A partially valid aligned vector means the columns drifted.
            if (skew) bus.Skew_Err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ub_writeback_deskew.sv
// Scoreboard bench for the write-back deskew stage: directed skewed rows are
// queued with their expected write, a negedge monitor pops and compares.
module tb_ub_writeback_deskew;
    localparam int SIZE = 8;
    localparam int W    = 19;
    localparam int AW   = 6;
    localparam int DW   = SIZE * W;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    ub_writeback_deskew_if #(
        .SIZE(SIZE), .PARTIAL_SUM_WIDTH(W), .ADDR_WIDTH(AW)
    ) bus ();

    ub_writeback_deskew #(
        .SIZE(SIZE), .PARTIAL_SUM_WIDTH(W), .ADDR_WIDTH(AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            last;
    } exp_t;

    exp_t         q[$];
    int           n_cmp     = 0;
    int           n_bad     = 0;
    int           cyc       = 0;
    bit           pend_done = 1'b0;
    logic [W-1:0] rows [SIZE][SIZE];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pack_row(input int r);
        logic [DW-1:0] v;
        for (int j = 0; j < SIZE; j++) v[j*W +: W] = rows[r][j];
        return v;
    endfunction

    function automatic logic [DW-1:0] wr_data();
        logic [DW-1:0] v;
        for (int j = 0; j < SIZE; j++) v[j*W +: W] = bus.Wr_Data[j];
        return v;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        bit   now_last;
        now_last = 1'b0;
        if (bus.Wr_en === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: addr %0d at cycle %0d, nothing expected",
                         bus.Wr_Addr, cyc);
            end else begin
                e = q.pop_front();
                check("wr_cycle", cyc, e.cyc);
                check("wr_addr", bus.Wr_Addr, e.addr);
                check("wr_data", wr_data(), e.data);
                now_last = e.last;
            end
        end
        check("done_pulse", bus.Done, pend_done);
        pend_done = now_last;
    end

    task automatic pulse_start();
        bus.Start = 1'b1;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
    endtask

    // Row r of column j is presented in cycle c+r+j (one cycle later for late_col).
    task automatic run_rows(input int n, input int late_col, input bit expect_wr,
                            input int first_addr);
        int              c;
        int              r;
        logic [SIZE-1:0] v;
        c = cyc;
        if (expect_wr) begin
            for (int k = 0; k < n; k++) begin
                q.push_back('{cyc:  c + k + SIZE,
                              addr: AW'(first_addr + k * SIZE),
                              data: pack_row(k),
                              last: (AW'(first_addr + k * SIZE) == AW'(56))});
            end
        end
        for (int t = 0; t < n + SIZE; t++) begin
            v = '0;
            for (int j = 0; j < SIZE; j++) begin
                r = t - j - ((j == late_col) ? 1 : 0);
                if (r >= 0 && r < n) begin
                    v[j]           = 1'b1;
                    bus.Psum_In[j] = rows[r][j];
                end else begin
                    bus.Psum_In[j] = W'($urandom());
                end
            end
            bus.Psum_Valid = v;
            @(posedge clk);
            #1;
        end
        bus.Psum_Valid = '0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_wr_en"}, bus.Wr_en, 0);
        check({tag, "_wr_addr"}, bus.Wr_Addr, 0);
        check({tag, "_wr_data"}, wr_data(), 0);
        check({tag, "_busy"}, bus.Busy, 0);
        check({tag, "_done"}, bus.Done, 0);
        check({tag, "_skew_err"}, bus.Skew_Err, 0);
    endtask

    initial begin
        bus.Start      = 1'b0;
        bus.Psum_Valid = '0;
        for (int j = 0; j < SIZE; j++) bus.Psum_In[j] = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Valids while idle must not produce writes.
        for (int j = 0; j < SIZE; j++) rows[0][j] = W'(j + 1);
        run_rows(1, -1, 1'b0, 0);
        check("idle_busy", bus.Busy, 0);
        repeat (3) @(posedge clk);
        #1;

        // One correctly skewed row.
        pulse_start();
        check("start_busy", bus.Busy, 1);
        run_rows(1, -1, 1'b1, 0);

        // Column 3 one cycle late: no write, sticky error.
        for (int j = 0; j < SIZE; j++) rows[0][j] = W'(100 + j);
        run_rows(1, 3, 1'b0, 0);
        check("skew_set", bus.Skew_Err, 1);
        check("skew_busy", bus.Busy, 1);

        // Start inside COLLECT is ignored; addresses continue at 8.
        pulse_start();
        check("mid_start_busy", bus.Busy, 1);
        check("mid_start_skew", bus.Skew_Err, 1);
        for (int r = 0; r < 7; r++)
            for (int j = 0; j < SIZE; j++) rows[r][j] = W'(32'h200 + r * 16 + j);
        run_rows(7, -1, 1'b1, 8);
        check("tileA_done", bus.Done, 1);
        check("tileA_busy", bus.Busy, 0);
        check("tileA_skew_held", bus.Skew_Err, 1);
        @(posedge clk);
        #1;
        check("tileA_idle_done", bus.Done, 0);

        // Full tile of back-to-back rows with signed extremes in row 0.
        pulse_start();
        check("restart_skew_clr", bus.Skew_Err, 0);
        for (int r = 0; r < SIZE; r++)
            for (int j = 0; j < SIZE; j++) rows[r][j] = W'(r * 16 + j);
        rows[0][0] = 19'h40000;
        rows[0][7] = 19'h3FFFF;
        run_rows(8, -1, 1'b1, 0);
        check("tileB_done", bus.Done, 1);
        @(posedge clk);
        #1;
        check("tileB_idle_busy", bus.Busy, 0);
        check("tileB_idle_done", bus.Done, 0);

        // Reset in the middle of row 4.
        pulse_start();
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < SIZE; j++) rows[r][j] = W'(32'h300 + r * 16 + j);
        run_rows(4, -1, 1'b1, 0);
        for (int t = 0; t < 3; t++) begin
            bus.Psum_Valid = SIZE'(1 << t);
            bus.Psum_In[t] = W'(32'h5A5A + t);
            @(posedge clk);
            #1;
        end
        #2 rst_n = 1'b0;
        #1;
        check_cleared("midrst");
        check("midrst_queue", q.size(), 0);
        bus.Psum_Valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.Psum_Valid = '1;
        repeat (10) @(posedge clk);
        #1;
        bus.Psum_Valid = '0;
        check("postrst_busy", bus.Busy, 0);

        pulse_start();
        for (int j = 0; j < SIZE; j++) rows[0][j] = W'(32'h7000 + j);
        run_rows(1, -1, 1'b1, 0);

        for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
        #1;
        check("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
